tx_pkt_queue: RTL and testbench
===============================

# tx_pkt_queue

Packet queue and request sequencer placed directly upstream of the serial link transmitter, in the transmitter's clock domain. It buffers whole packets (header + payload + address) from the router output port. One packet at a time, it issues a single-cycle `req` with the packet on `item_out`, then waits for the transmitter's `tx_busy` to rise and fall before launching the next. Overflow and accept-timeout conditions are reported as sticky flags.

## Interface
- `DEPTH`, 4: packet slots; power of two, ≥2.
- `GUARD`, 4: cycles to wait for `tx_busy` to rise after `req` before declaring a timeout.
- `PKT_W`, `` `HDR_SZ + `PL_SZ + `ADDR_SZ ``: packet width.
- `clk`  in  1  transmitter clock (the `wclk` domain).
- `reset`  in  1  asynchronous, active-high.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  PKT_W  packet to enqueue.
- `full`  out  1  no free slot; combinational from occupancy.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `req`  out  1  one-cycle launch strobe to the transmitter.
- `item_out`  out  PKT_W  registered packet; valid and stable in the `req` cycle.
- `tx_busy`  in  1  transmitter shifting; rises ≤`GUARD` cycles after `req`.
- `overflow`  out  1  sticky: a push was attempted while full.
- `timeout`  out  1  sticky: `tx_busy` did not rise within `GUARD` cycles.
- `sent`  out  16  packets launched; wraps at 0xFFFF→0.

## Operation
- Reset (asynchronous, immediate): FIFO empty, `count`=0, `full`=0, `req`=0, `item_out`=0, `overflow`=0, `timeout`=0, `sent`=0, FSM=IDLE. Asserting reset mid-transfer discards all queued packets and the in-flight packet.
- Push: `wr_en & !full` writes `wr_data` at the tail. `wr_en & full` drops the packet and sets `overflow`.
- FSM states:
  - IDLE: if `count≠0 & !tx_busy`, load the head into `item_out` and go to ISSUE.
  - ISSUE: `req`=1 for exactly this cycle. Pop the head, `sent`+=1, clear the guard counter, go to WAIT_UP.
  - WAIT_UP: on `tx_busy`=1 go to WAIT_DN. If the guard counter reaches `GUARD` with `tx_busy` still 0, set `timeout` and go to IDLE.
  - WAIT_DN: on `tx_busy`=0 go to IDLE.
- The packet is popped at ISSUE. It is not replayed on timeout.
- `item_out` holds its value until the next load.
- Push and pop in the same cycle: `count` unchanged. `full` is evaluated from the pre-edge occupancy, so a push while full is dropped even when a pop occurs in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal. Empty = pointers equal.

## Timing
- Empty queue, push at edge N: `count`=1 after N. FSM enters ISSUE at N+1, so `req`=1 in cycle N+1→N+2.
- Minimum spacing between two `req` pulses = 2 + cycles `tx_busy` spends high + 1 (WAIT_DN→IDLE→ISSUE).
- `tx_busy` already high in IDLE: no issue until it falls.
- `sent` and `count` update on the same edge that ends ISSUE.
- All outputs are registered except `full`, which is decoded from the pointers.

## Structure
- `HDR_SZ`, `PL_SZ`, and `ADDR_SZ` come from the shared constants file. Add `` `TXQ_SENT_W `` = 16 there.
- Sub-module `pkt_fifo` (parameters DEPTH, PKT_W) provides storage, pointers, `count`, and `full`/`empty`, with a separate push/pop interface.
- The FSM, guard counter, and status logic live in `tx_pkt_queue`.

## Test plan
- Reset mid-WAIT_DN with 3 packets queued → all outputs are 0 immediately, and no `req` follows until new pushes arrive.
- Push 0x01 into an empty queue; a model transmitter raises `tx_busy` 1 cycle after `req` for 20 cycles → `req` occurs exactly once, `item_out`=0x01 in the `req` cycle, `sent`=1, `count`=0.
- Push 4 packets (0x01, 0x02, 0x03, 0xFF) back-to-back with DEPTH=4, then push a 5th → `full`=1 after the 4th, `overflow`=1 after the 5th, and the output order is 0x01, 0x02, 0x03, 0xFF with no 5th `req`.
- Simultaneous push and pop with `count`=2 → `count` stays 2 and FIFO order is preserved across pointer wrap (≥10 packets streamed).
- `tx_busy` held 0 after `req` → `timeout`=1 exactly GUARD+1 cycles after the ISSUE edge, and the next queued packet is issued afterwards.
- `tx_busy` held high from reset release with 2 packets queued → no `req` while high, and the first `req` occurs 1 cycle after it falls.

Source files
------------

// File: rtl/tx_pkt_queue_pkg.sv
// Shared link constants plus the types used by the transmit packet queue.
// The width macros are guarded so any file of the link may carry them too.
`ifndef TXQ_CONSTS_SVH
`define TXQ_CONSTS_SVH
`define HDR_SZ 4
`define PL_SZ 8
`define ADDR_SZ 4
`define TXQ_SENT_W 16
`endif

package tx_pkt_queue_pkg;
  localparam int PKT_W_DEF = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int SENT_W    = `TXQ_SENT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_UP,
    ST_WAIT_DN
  } txq_state_e;
endpackage

// File: rtl/pkt_fifo.sv
// Packet storage with wrap-bit pointers; push and pop are independent ports.
// The head word is presented continuously so the caller can register it.
module pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [PKT_W-1:0]         push_data,
  input  logic                     pop,
  output logic [PKT_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Extra MSB distinguishes a full ring from an empty one.
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr_reg[AW-1:0]];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/tx_pkt_queue.sv
// Packet queue feeding the serial transmitter: one req per packet, then waits
// for tx_busy to rise and fall. Overflow and accept timeout are sticky.
module tx_pkt_queue
  import tx_pkt_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GUARD = 4,
  parameter int PKT_W = PKT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [PKT_W-1:0]       wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   req,
  output logic [PKT_W-1:0]       item_out,
  input  logic                   tx_busy,
  output logic                   overflow,
  output logic                   timeout,
  output logic [SENT_W-1:0]      sent
);
  localparam int GW = $clog2(GUARD + 1);

  txq_state_e        state_reg;
  logic              req_reg;
  logic [PKT_W-1:0]  item_reg;
  logic              overflow_reg;
  logic              timeout_reg;
  logic [SENT_W-1:0] sent_reg;
  logic [GW-1:0]     guard_reg;
  logic [PKT_W-1:0]  head_data;
  logic              empty;
  logic              pop;

  // The head leaves the ring on the same edge that ends the req cycle.
  assign pop = (state_reg == ST_ISSUE);

  pkt_fifo #(
    .DEPTH(DEPTH),
    .PKT_W(PKT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .head_data(head_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      item_reg     <= '0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      sent_reg     <= '0;
      guard_reg    <= '0;
    end else begin
      req_reg <= 1'b0;
      if (wr_en && full) overflow_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (!empty && !tx_busy) begin
            item_reg  <= head_data;
            req_reg   <= 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sent_reg  <= sent_reg + 1'b1;
          guard_reg <= '0;
          state_reg <= ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          // A timed-out packet is already popped and is not replayed.
          if (tx_busy) begin
            state_reg <= ST_WAIT_DN;
          end else if (guard_reg == GW'(GUARD)) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            guard_reg <= guard_reg + 1'b1;
          end
        end
        ST_WAIT_DN: begin
          if (!tx_busy) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req      = req_reg;
  assign item_out = item_reg;
  assign overflow = overflow_reg;
  assign timeout  = timeout_reg;
  assign sent     = sent_reg;
endmodule

// File: tb/tb_tx_pkt_queue.sv
// Directed bench for tx_pkt_queue with a simple transmitter model and req log.
module tb_tx_pkt_queue;
  import tx_pkt_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int GUARD = 4;
  localparam int PKT_W = PKT_W_DEF;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [PKT_W-1:0]  wr_data;
  logic              full;
  logic [CW-1:0]     count;
  logic              req;
  logic [PKT_W-1:0]  item_out;
  logic              tx_busy;
  logic              overflow;
  logic              timeout;
  logic [SENT_W-1:0] sent;

  logic busy_force;
  logic model_en;
  int   busy_len;
  logic busy_m;
  int   busy_cnt;

  logic [PKT_W-1:0] req_log[$];

  int tests = 0;
  int fails = 0;

  tx_pkt_queue #(.DEPTH(DEPTH), .GUARD(GUARD), .PKT_W(PKT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .req     (req),
    .item_out(item_out),
    .tx_busy (tx_busy),
    .overflow(overflow),
    .timeout (timeout),
    .sent    (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = model_en ? busy_m : busy_force;

  // Transmitter model: busy rises right after the req cycle, stays busy_len cycles.
  initial begin
    busy_m   = 1'b0;
    busy_cnt = 0;
  end
  always @(posedge clk) begin
    automatic logic r = req;
    #1;
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy_m = 1'b0;
    end
    if (r === 1'b1 && model_en) begin
      busy_m   = 1'b1;
      busy_cnt = busy_len;
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b0 && req === 1'b1) req_log.push_back(item_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PKT_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, {31'd0, req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    busy_force = 1'b0;
    model_en   = 1'b0;
    busy_len   = 20;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_full", {31'd0, full}, 0);
    check("rst_req", {31'd0, req}, 0);
    check("rst_item", 32'(item_out), 0);
    check("rst_sent", 32'(sent), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // A: single packet, busy for 20 cycles
    model_en = 1'b1;
    busy_len = 20;
    push(16'h01);
    check("A_count1", 32'(count), 1);
    tick();
    check("A_req", {31'd0, req}, 1);
    check("A_item", 32'(item_out), 32'h01);
    tick();
    check("A_req_low", {31'd0, req}, 0);
    check("A_sent", 32'(sent), 1);
    check("A_count0", 32'(count), 0);
    repeat (30) tick();
    check("A_nreq", req_log.size(), 1);
    check("A_log0", 32'(req_log[0]), 32'h01);
    req_log.delete();

    // B: fill to full, overflow, then drain in order
    model_en   = 1'b0;
    busy_force = 1'b1;
    push(16'h01);
    push(16'h02);
    push(16'h03);
    check("B_full3", {31'd0, full}, 0);
    push(16'hFF);
    check("B_full4", {31'd0, full}, 1);
    check("B_count4", 32'(count), 4);
    check("B_ovf_pre", {31'd0, overflow}, 0);
    push(16'h55);
    check("B_ovf", {31'd0, overflow}, 1);
    check("B_count_ovf", 32'(count), 4);
    busy_len = 2;
    model_en = 1'b1;
    repeat (60) tick();
    check("B_nreq", req_log.size(), 4);
    check("B_log0", 32'(req_log[0]), 32'h01);
    check("B_log1", 32'(req_log[1]), 32'h02);
    check("B_log2", 32'(req_log[2]), 32'h03);
    check("B_log3", 32'(req_log[3]), 32'hFF);
    check("B_sent", 32'(sent), 5);
    check("B_count0", 32'(count), 0);
    req_log.delete();

    // C: streaming push/pop with two packets resident, across pointer wrap
    model_en   = 1'b0;
    busy_force = 1'b1;
    push(16'h10);
    push(16'h11);
    check("C_count2", 32'(count), 2);
    busy_len = 1;
    model_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_req("C_wait_req");
      push(16'(16'h12 + k));
      check("C_count_pp", 32'(count), 2);
    end
    repeat (40) tick();
    check("C_nreq", req_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check("C_order", 32'(req_log[i]), 32'(32'h10 + i));
    end
    check("C_sent", 32'(sent), 17);
    req_log.delete();

    // D: transmitter never responds -> timeout after GUARD+1 cycles
    model_en   = 1'b0;
    busy_force = 1'b1;
    push(16'h20);
    push(16'h21);
    busy_force = 1'b0;
    wait_req("D_req1");
    check("D_item1", 32'(item_out), 32'h20);
    tick();
    check("D_to_e0", {31'd0, timeout}, 0);
    check("D_sent", 32'(sent), 18);
    repeat (GUARD) tick();
    check("D_to_early", {31'd0, timeout}, 0);
    tick();
    check("D_to_set", {31'd0, timeout}, 1);
    tick();
    check("D_req2", {31'd0, req}, 1);
    check("D_item2", 32'(item_out), 32'h21);
    repeat (GUARD + 4) tick();
    check("D_count0", 32'(count), 0);
    check("D_sent2", 32'(sent), 19);

    // E: reset in WAIT_DN with three packets queued
    busy_force = 1'b0;
    busy_len   = 20;
    model_en   = 1'b1;
    push(16'h40);
    push(16'h41);
    push(16'h42);
    push(16'h43);
    check("E_count3", 32'(count), 3);
    check("E_item", 32'(item_out), 32'h40);
    tick();
    tick();
    #2;
    reset    = 1'b1;
    model_en = 1'b0;
    #1;
    check("E_rst_count", 32'(count), 0);
    check("E_rst_item", 32'(item_out), 0);
    check("E_rst_to", {31'd0, timeout}, 0);
    check("E_rst_ovf", {31'd0, overflow}, 0);
    check("E_rst_sent", 32'(sent), 0);
    tick();
    reset = 1'b0;
    req_log.delete();
    repeat (10) tick();
    check("E_noreq", req_log.size(), 0);
    check("E_count_after", 32'(count), 0);

    // F: tx_busy high from reset release, two packets wait until it falls
    reset      = 1'b1;
    busy_force = 1'b1;
    tick();
    reset = 1'b0;
    push(16'h30);
    push(16'h31);
    repeat (5) tick();
    check("F_noreq", req_log.size(), 0);
    check("F_count2", 32'(count), 2);
    busy_force = 1'b0;
    tick();
    check("F_req", {31'd0, req}, 1);
    check("F_item", 32'(item_out), 32'h30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
